// File: rtl/resv_dispatch_ctrl_pkg.sv
// rtl/resv_dispatch_ctrl_pkg.sv - shared encodings for dispatch, decode and the reservation stations
package resv_dispatch_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } disp_state_t;

  localparam logic [2:0] C_LSU_CLS = 3'b100;
  localparam int         CLS_MSB   = 5;
  localparam int         CLS_LSB   = 3;
  localparam logic [5:0] UNUSED_OP = 6'h3F;

  function automatic logic is_lsu(input logic [5:0] uops);
    return uops[CLS_MSB:CLS_LSB] == C_LSU_CLS;
  endfunction

endpackage

// File: rtl/resv_credit_ctr.sv
// rtl/resv_credit_ctr.sv - per-RS occupancy counter, saturates at zero and flags underflow
module resv_credit_ctr #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         clear,
  input  logic         zero,
  input  logic         inc,
  input  logic [1:0]   dec,
  output logic [W-1:0] occ,
  output logic         err
);

  logic [W:0] sum;

  // One extra bit so a release larger than the count shows up as a set MSB.
  always_comb sum = {1'b0, occ} + {{W{1'b0}}, inc} - {{(W-1){1'b0}}, dec};

  always_ff @(posedge clk) begin
    if (clear) begin
      occ <= '0;
      err <= 1'b0;
    end else if (zero) begin
      occ <= '0;
    end else if (sum[W]) begin
      occ <= '0;
      err <= 1'b1;
    end else begin
      occ <= sum[W-1:0];
    end
  end

endmodule

// File: rtl/resv_dispatch_ctrl.sv
// rtl/resv_dispatch_ctrl.sv - steers decoded uops to the ALU/LSU reservation stations with credit flow control
module resv_dispatch_ctrl
  import resv_dispatch_ctrl_pkg::*;
#(
  parameter int W_PD_UOPS = 6,
  parameter int W_PD_PAY  = 134,
  parameter int S_PS_rsvc = 8,
  parameter int W_PS_rsvc = 4,
  parameter int FLUSH_CYC = 2
) (
  input  logic                 clk,
  input  logic                 CFI_PC_clear,
  input  logic                 CFI_PC_flush,
  input  logic                 DFI_PV_in,
  input  logic [W_PD_UOPS-1:0] DFI_PD_uops,
  input  logic [W_PD_PAY-1:0]  DFI_PD_pay,
  input  logic [1:0]           CDI_PC_rel0,
  input  logic [1:0]           CDI_PC_rel1,
  output logic                 CFO_PC_stall,
  output logic                 CFO_PC_ena0,
  output logic                 CFO_PC_ena1,
  output logic                 CFO_PC_rsclr,
  output logic [W_PD_UOPS-1:0] DFO_PD_uops,
  output logic [W_PD_PAY-1:0]  DFO_PD_pay,
  output logic                 CFO_PC_err
);

  localparam int FCW = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;

  disp_state_t state_q, state_d;
  logic [FCW-1:0] fcnt_q, fcnt_d;

  logic                 stg_vld, stg_tgt, skd_vld, skd_tgt;
  logic [W_PD_UOPS-1:0] stg_uops, skd_uops;
  logic [W_PD_PAY-1:0]  stg_pay, skd_pay;
  logic                 rsclr_q;

  logic [W_PS_rsvc-1:0] occ0, occ1;
  logic                 err0, err1;
  logic                 in_flush, dispatch, accept, stage_free, skid_wr, skid_drain, in_tgt;
  logic [1:0]           rel0_eff, rel1_eff;

  assign in_flush   = (state_q == ST_FLUSH);
  assign in_tgt     = (DFI_PD_uops[CLS_MSB:CLS_LSB] == C_LSU_CLS);
  assign CFO_PC_ena0 = !in_flush && stg_vld && !stg_tgt && (occ0 < W_PS_rsvc'(S_PS_rsvc));
  assign CFO_PC_ena1 = !in_flush && stg_vld &&  stg_tgt && (occ1 < W_PS_rsvc'(S_PS_rsvc));
  assign dispatch   = CFO_PC_ena0 || CFO_PC_ena1;
  assign CFO_PC_stall = (state_q != ST_RUN);
  assign accept     = DFI_PV_in && !CFO_PC_stall;
  assign stage_free = !stg_vld || dispatch;
  assign skid_wr    = accept && !stage_free;
  assign skid_drain = skd_vld && stage_free;

  assign CFO_PC_rsclr = rsclr_q;
  assign DFO_PD_uops  = stg_uops;
  assign DFO_PD_pay   = stg_pay;
  assign CFO_PC_err   = err0 || err1;

  // Releases during a flush refer to entries that the RS is clearing anyway.
  assign rel0_eff = in_flush ? 2'd0 : CDI_PC_rel0;
  assign rel1_eff = in_flush ? 2'd0 : CDI_PC_rel1;

  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    if (CFI_PC_flush) begin
      state_d = ST_FLUSH;
      fcnt_d  = FCW'(FLUSH_CYC - 1);
    end else begin
      case (state_q)
        ST_RUN:   if (skid_wr) state_d = ST_STALL;
        ST_STALL: if (skid_drain) state_d = ST_RUN;
        ST_FLUSH: begin
          if (fcnt_q == '0) state_d = ST_RUN;
          else              fcnt_d  = fcnt_q - 1'b1;
        end
        default:  state_d = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (CFI_PC_clear) begin
      state_q  <= ST_RUN;
      fcnt_q   <= '0;
      stg_vld  <= 1'b0;
      stg_tgt  <= 1'b0;
      stg_uops <= W_PD_UOPS'(UNUSED_OP);
      stg_pay  <= '0;
      skd_vld  <= 1'b0;
      skd_tgt  <= 1'b0;
      skd_uops <= W_PD_UOPS'(UNUSED_OP);
      skd_pay  <= '0;
      rsclr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      rsclr_q <= CFI_PC_flush;
      if (CFI_PC_flush) begin
        stg_vld <= 1'b0;
        skd_vld <= 1'b0;
      end else if (stage_free) begin
        // The skid is older than anything on decode, so it refills the stage first.
        if (skd_vld) begin
          stg_vld  <= 1'b1;
          stg_tgt  <= skd_tgt;
          stg_uops <= skd_uops;
          stg_pay  <= skd_pay;
          skd_vld  <= 1'b0;
        end else if (accept) begin
          stg_vld  <= 1'b1;
          stg_tgt  <= in_tgt;
          stg_uops <= DFI_PD_uops;
          stg_pay  <= DFI_PD_pay;
        end else begin
          stg_vld  <= 1'b0;
        end
      end else if (accept) begin
        skd_vld  <= 1'b1;
        skd_tgt  <= in_tgt;
        skd_uops <= DFI_PD_uops;
        skd_pay  <= DFI_PD_pay;
      end
    end
  end

  resv_credit_ctr #(.W(W_PS_rsvc)) u_cred0 (
    .clk   (clk),
    .clear (CFI_PC_clear),
    .zero  (CFI_PC_flush),
    .inc   (CFO_PC_ena0),
    .dec   (rel0_eff),
    .occ   (occ0),
    .err   (err0)
  );

  resv_credit_ctr #(.W(W_PS_rsvc)) u_cred1 (
    .clk   (clk),
    .clear (CFI_PC_clear),
    .zero  (CFI_PC_flush),
    .inc   (CFO_PC_ena1),
    .dec   (rel1_eff),
    .occ   (occ1),
    .err   (err1)
  );

endmodule
